// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes held-level I-port and D-port requests from the
// CPU pipeline onto one word-wide physical memory port. One transaction is
// outstanding at a time; completion is reported with a one-cycle resp pulse.
// D requests win unless an I fetch has already been passed over
// MAX_D_STREAK times in a row, in which case the fetch is forced through.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_enable,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0]  C_MAX_STREAK = 4'(MAX_D_STREAK);
    localparam logic [31:0] C_WORD_MASK  = 32'hFFFF_FFFC;

    // Clear the byte offset so the memory always sees a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & C_WORD_MASK;
    endfunction

    state_t      r_state,    w_state_nxt;
    logic [3:0]  r_streak,   w_streak_nxt;
    logic        r_pmem_read,  w_pmem_read_nxt;
    logic        r_pmem_write, w_pmem_write_nxt;
    logic [31:0] r_pmem_address, w_pmem_address_nxt;
    logic [31:0] r_pmem_wdata,   w_pmem_wdata_nxt;
    logic [3:0]  r_pmem_be,      w_pmem_be_nxt;
    logic        r_i_resp,   w_i_resp_nxt;
    logic        r_d_resp,   w_d_resp_nxt;
    logic [31:0] r_i_rdata,  w_i_rdata_nxt;
    logic [31:0] r_d_rdata,  w_d_rdata_nxt;
    logic        w_d_req;

    assign w_d_req = d_read | d_write;

    // State and every output register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_streak       <= 4'd0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 32'h0;
            r_pmem_wdata   <= 32'h0;
            r_pmem_be      <= 4'h0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
            r_i_rdata      <= 32'h0;
            r_d_rdata      <= 32'h0;
        end else begin
            r_state        <= w_state_nxt;
            r_streak       <= w_streak_nxt;
            r_pmem_read    <= w_pmem_read_nxt;
            r_pmem_write   <= w_pmem_write_nxt;
            r_pmem_address <= w_pmem_address_nxt;
            r_pmem_wdata   <= w_pmem_wdata_nxt;
            r_pmem_be      <= w_pmem_be_nxt;
            r_i_resp       <= w_i_resp_nxt;
            r_d_resp       <= w_d_resp_nxt;
            r_i_rdata      <= w_i_rdata_nxt;
            r_d_rdata      <= w_d_rdata_nxt;
        end
    end

    // Grant decision, memory handshake and response generation.
    always_comb begin
        w_state_nxt        = r_state;
        w_streak_nxt       = r_streak;
        w_pmem_read_nxt    = r_pmem_read;
        w_pmem_write_nxt   = r_pmem_write;
        w_pmem_address_nxt = r_pmem_address;
        w_pmem_wdata_nxt   = r_pmem_wdata;
        w_pmem_be_nxt      = r_pmem_be;
        w_i_resp_nxt       = 1'b0;
        w_d_resp_nxt       = 1'b0;
        w_i_rdata_nxt      = 32'h0;
        w_d_rdata_nxt      = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_req && (!i_read || (r_streak < C_MAX_STREAK))) begin
                    // A simultaneous read+write is issued as a write.
                    w_state_nxt        = ST_D_BUSY;
                    w_pmem_write_nxt   = d_write;
                    w_pmem_read_nxt    = ~d_write;
                    w_pmem_address_nxt = word_align(d_addr);
                    w_pmem_wdata_nxt   = d_wdata;
                    w_pmem_be_nxt      = d_write ? d_byte_enable : 4'hF;
                    if (i_read) begin
                        w_streak_nxt = (r_streak < C_MAX_STREAK) ? (r_streak + 4'd1) : C_MAX_STREAK;
                    end else begin
                        w_streak_nxt = 4'd0;
                    end
                end else if (i_read) begin
                    w_state_nxt        = ST_I_BUSY;
                    w_pmem_read_nxt    = 1'b1;
                    w_pmem_write_nxt   = 1'b0;
                    w_pmem_address_nxt = word_align(i_addr);
                    w_pmem_wdata_nxt   = 32'h0;
                    w_pmem_be_nxt      = 4'hF;
                    w_streak_nxt       = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                if (pmem_resp) begin
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                    w_state_nxt      = ST_RESP;
                    // A flushed fetch completes silently.
                    if (i_read) begin
                        w_i_resp_nxt  = 1'b1;
                        w_i_rdata_nxt = pmem_rdata;
                    end else begin
                        w_i_resp_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_I_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (pmem_resp) begin
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                    w_state_nxt      = ST_RESP;
                    if (w_d_req) begin
                        w_d_resp_nxt  = 1'b1;
                        w_d_rdata_nxt = r_pmem_write ? 32'h0 : pmem_rdata;
                    end else begin
                        w_d_resp_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_D_BUSY;
                end
            end
            ST_RESP: begin
                // Requests are ignored here so the one just answered is not regranted.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pmem_read        = r_pmem_read;
    assign pmem_write       = r_pmem_write;
    assign pmem_address     = r_pmem_address;
    assign pmem_wdata       = r_pmem_wdata;
    assign pmem_byte_enable = r_pmem_be;
    assign i_resp           = r_i_resp;
    assign i_rdata          = r_i_rdata;
    assign d_resp           = r_d_resp;
    assign d_rdata          = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a randomized-latency memory responder plus a
// reference model of the arbitration and response rules, checked every cycle.
module tb_mem_port_arbiter;

    localparam int MAXS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Responder latency window (cycles between strobe appearing and pmem_resp).
    int lat_min = 0;
    int lat_max = 0;

    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    // Unwritten words read back as a fixed function of their address;
    // chosen so that word 0x6000_0004 holds 0xDEADBEEF.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hBEAD_BEEB;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Physical memory: answers each strobe once, after a random latency.
    initial begin : responder
        int  cnt;
        bit  busy;
        cnt = 0;
        busy = 1'b0;
        pmem_resp = 1'b0;
        pmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pmem_rdata = 32'h0;
                busy = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = int'($urandom_range(lat_max, lat_min));
                end
                if (cnt == 0) begin
                    if (pmem_write) begin
                        phys_mem[pmem_address] = merge_lanes(
                            phys_mem.exists(pmem_address) ? phys_mem[pmem_address] : init_word(pmem_address),
                            pmem_wdata, pmem_byte_enable);
                    end else begin
                        pmem_rdata = phys_mem.exists(pmem_address) ? phys_mem[pmem_address] : init_word(pmem_address);
                    end
                    pmem_resp = 1'b1;
                end else begin
                    cnt = cnt - 1;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model state (written only by the main sequence).
    int          cyc = 0;
    bit          model_on = 1'b0;
    int          free_cycle = 0;
    bit          exp_busy = 1'b0;
    bit          exp_port_d = 1'b0;
    bit          exp_wr = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic [3:0]  exp_be = 4'h0;
    int          streak = 0;
    bit          presp_prev = 1'b0;
    bit          saw_i = 1'b0;
    bit          saw_d = 1'b0;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_txn();
        chk1("txn_read", pmem_read, !exp_wr);
        chk1("txn_write", pmem_write, exp_wr);
        chk("txn_addr", pmem_address, exp_addr);
        chk("txn_be", {28'h0, pmem_byte_enable}, {28'h0, exp_be});
        if (exp_wr) chk("txn_wdata", pmem_wdata, exp_wdata);
    endtask

    task automatic check_zero_outputs();
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, 32'h0);
        chk("rst_pmem_be", {28'h0, pmem_byte_enable}, 32'h0);
        chk1("rst_i_resp", i_resp, 1'b0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk1("rst_d_resp", d_resp, 1'b0);
        chk("rst_d_rdata", d_rdata, 32'h0);
    endtask

    // Compare one cycle of DUT outputs with the rules; the input drives seen
    // here are still the ones the DUT sampled at the edge that just passed.
    task automatic check_cycle();
        logic        e_iresp, e_dresp, d_req, grant_d;
        logic [31:0] e_irdata, e_drdata;
        e_iresp = 1'b0;
        e_dresp = 1'b0;
        e_irdata = 32'h0;
        e_drdata = 32'h0;
        d_req = d_read | d_write;
        if (presp_prev && exp_busy) begin
            if (exp_wr) ref_mem[exp_addr] = merge_lanes(ref_rd(exp_addr), exp_wdata, exp_be);
            if (exp_port_d && d_req) begin
                e_dresp = 1'b1;
                e_drdata = exp_wr ? 32'h0 : exp_rdata;
            end
            if (!exp_port_d && i_read) begin
                e_iresp = 1'b1;
                e_irdata = exp_rdata;
            end
            exp_busy = 1'b0;
            free_cycle = cyc + 1;
            chk1("strobe_rd_after_resp", pmem_read, 1'b0);
            chk1("strobe_wr_after_resp", pmem_write, 1'b0);
        end else if (exp_busy) begin
            chk_txn();
        end else if ((cyc - 1 >= free_cycle) && (d_req || i_read)) begin
            grant_d = d_req && (!i_read || streak < MAXS);
            if (grant_d) begin
                exp_port_d = 1'b1;
                exp_wr = d_write;
                exp_addr = d_addr & 32'hFFFF_FFFC;
                exp_wdata = d_wdata;
                exp_be = d_write ? d_byte_enable : 4'hF;
                streak = i_read ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else begin
                exp_port_d = 1'b0;
                exp_wr = 1'b0;
                exp_addr = i_addr & 32'hFFFF_FFFC;
                exp_be = 4'hF;
                streak = 0;
            end
            exp_rdata = ref_rd(exp_addr);
            exp_busy = 1'b1;
            grants.push_back(grant_d ? 1 : 0);
            chk_txn();
        end else begin
            chk1("idle_read", pmem_read, 1'b0);
            chk1("idle_write", pmem_write, 1'b0);
        end
        chk1("i_resp", i_resp, e_iresp);
        chk("i_rdata", i_rdata, e_irdata);
        chk1("d_resp", d_resp, e_dresp);
        chk("d_rdata", d_rdata, e_drdata);
        presp_prev = pmem_resp;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (model_on) check_cycle();
        saw_i = i_resp;
        saw_d = d_resp;
    endtask

    task automatic model_reset();
        exp_busy = 1'b0;
        presp_prev = 1'b0;
        streak = 0;
        free_cycle = cyc;
        model_on = 1'b1;
    endtask

    task automatic wait_resp(input bit want_d, input int bound, input string tag);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            step();
            n++;
            got = want_d ? saw_d : saw_i;
        end
        chk1(tag, got, 1'b1);
    endtask

    task automatic new_i();
        i_read = 1'b1;
        i_addr = 32'h6000_0000 | {20'h0, 12'($urandom_range(4095, 0))};
    endtask

    task automatic new_d();
        int kind;
        kind = int'($urandom_range(2, 0));
        d_read = (kind != 1);
        d_write = (kind != 0);
        d_addr = {24'h0, 8'($urandom_range(63, 0))};
        d_wdata = $urandom;
        d_byte_enable = 4'($urandom_range(15, 0));
    endtask

    initial begin : main
        int k;
        int cnt;
        int d_before_i;
        bit i_seen;
        int pattern [6];

        rst = 1'b0;
        i_read = 1'b0;
        i_addr = 32'h0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        d_byte_enable = 4'h0;

        // Reset state
        step();
        check_zero_outputs();
        step();
        rst = 1'b1;
        model_reset();
        repeat (3) step();

        // Single fetch, memory answers two cycles after the strobe appears
        lat_min = 2;
        lat_max = 2;
        i_read = 1'b1;
        i_addr = 32'h6000_0006;
        k = 0;
        saw_i = 1'b0;
        while (!saw_i && k < 20) begin
            step();
            k++;
            if (!saw_i) begin
                chk("fetch_addr", pmem_address, 32'h6000_0004);
                chk1("fetch_strobe", pmem_read, 1'b1);
            end
        end
        chk("fetch_latency", k, 4);
        chk("fetch_data", i_rdata, 32'hDEAD_BEEF);
        chk1("fetch_strobe_drop", pmem_read, 1'b0);
        i_read = 1'b0;
        step();
        chk1("fetch_single_pulse", i_resp, 1'b0);

        // Store with partial lanes, then read it back unaligned
        lat_min = 0;
        lat_max = 3;
        d_write = 1'b1;
        d_addr = 32'h0000_0100;
        d_wdata = 32'h1234_5678;
        d_byte_enable = 4'b0011;
        step();
        chk1("store_write", pmem_write, 1'b1);
        chk("store_addr", pmem_address, 32'h0000_0100);
        chk("store_wdata", pmem_wdata, 32'h1234_5678);
        chk("store_be", {28'h0, pmem_byte_enable}, 32'h3);
        wait_resp(1'b1, 20, "store_resp");
        chk("store_rdata", d_rdata, 32'h0);
        d_write = 1'b0;
        step();
        chk1("store_single_pulse", d_resp, 1'b0);
        d_read = 1'b1;
        d_addr = 32'h0000_0102;
        wait_resp(1'b1, 20, "load_resp");
        chk("load_merged", d_rdata, 32'hBEAD_5678);
        d_read = 1'b0;
        step();

        // Read and write together are issued as a write
        d_read = 1'b1;
        d_write = 1'b1;
        d_addr = 32'h0000_0104;
        d_wdata = 32'hAABB_CCDD;
        d_byte_enable = 4'hF;
        step();
        chk1("both_write", pmem_write, 1'b1);
        chk1("both_read", pmem_read, 1'b0);
        wait_resp(1'b1, 20, "both_resp");
        d_read = 1'b0;
        d_write = 1'b0;
        step();

        // Contention: I held, D re-presented continuously
        grants.delete();
        pattern = '{1, 1, 0, 1, 1, 0};
        new_i();
        new_d();
        k = 0;
        d_before_i = 0;
        i_seen = 1'b0;
        while (grants.size() < 6 && k < 300) begin
            step();
            k++;
            if (saw_d) begin
                if (!i_seen) d_before_i++;
                new_d();
            end
            if (saw_i) begin
                i_seen = 1'b1;
                new_i();
            end
        end
        for (int g = 0; g < 6; g++) begin
            chk("grant_order", (g < grants.size()) ? grants[g] : -1, pattern[g]);
        end
        chk("d_before_i", d_before_i, 2);
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        repeat (12) step();

        // Withdrawal: fetch dropped one cycle after its grant
        lat_min = 3;
        lat_max = 3;
        i_read = 1'b1;
        i_addr = 32'h6000_0040;
        k = 0;
        do begin
            step();
            k++;
        end while (!pmem_read && k < 10);
        chk1("wd_grant", pmem_read, 1'b1);
        step();
        i_read = 1'b0;
        cnt = 0;
        repeat (8) begin
            step();
            if (saw_i) cnt++;
        end
        chk("wd_no_resp", cnt, 0);
        lat_min = 0;
        lat_max = 3;
        d_read = 1'b1;
        d_addr = 32'h0000_0020;
        wait_resp(1'b1, 20, "wd_next_resp");
        d_read = 1'b0;
        step();

        // Reset while a D read is outstanding
        lat_min = 20;
        lat_max = 20;
        d_read = 1'b1;
        d_addr = 32'h0000_0030;
        k = 0;
        do begin
            step();
            k++;
        end while (!pmem_read && k < 10);
        chk1("rst_busy_strobe", pmem_read, 1'b1);
        #2;
        rst = 1'b0;
        model_on = 1'b0;
        #1;
        check_zero_outputs();
        d_read = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_reset();
        cnt = 0;
        repeat (6) begin
            step();
            if (saw_d) cnt++;
            chk1("post_rst_idle", pmem_read, 1'b0);
        end
        chk("rst_no_resp", cnt, 0);

        // Randomized traffic on both ports against the model
        lat_min = 0;
        lat_max = 3;
        repeat (1500) begin
            step();
            if (i_read) begin
                if (saw_i) begin
                    if ($urandom_range(1, 0) == 1) new_i(); else i_read = 1'b0;
                end else if ($urandom_range(15, 0) == 0) begin
                    i_read = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                new_i();
            end
            if (d_read || d_write) begin
                if (saw_d) begin
                    if ($urandom_range(1, 0) == 1) new_d();
                    else begin
                        d_read = 1'b0;
                        d_write = 1'b0;
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    d_read = 1'b0;
                    d_write = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                new_d();
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder side of the CPU instruction/data memory protocol.
- Accepts held-level requests from the pipeline's I-port (i_read) and D-port (d_read/d_write with byte enables) and serializes them onto one word-wide physical memory port.
- Returns a one-cycle i_resp/d_resp pulse carrying read data.
- Sits between the CPU core and the memory/cache subsystem; the core stalls until it sees the response.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while an I request waits before I is forced through (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
i_read  in  1  instruction fetch request, held until i_resp
i_addr  in  32  fetch byte address
i_rdata  out  32  fetch data, valid only while i_resp=1
i_resp  out  1  one-cycle completion pulse for I-port
d_read  in  1  data load request, held until d_resp
d_write  in  1  data store request, held until d_resp
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_byte_enable  in  4  store byte lanes
d_rdata  out  32  load data, valid only while d_resp=1
d_resp  out  1  one-cycle completion pulse for D-port
pmem_read  out  1  memory read strobe, held until pmem_resp
pmem_write  out  1  memory write strobe, held until pmem_resp
pmem_address  out  32  word-aligned address, bits[1:0] always 0
pmem_wdata  out  32  write data
pmem_byte_enable  out  4  write lanes; 4'b1111 on reads
pmem_rdata  in  32  read data, valid with pmem_resp
pmem_resp  in  1  memory completion, one cycle

Behaviour:

Reset:
- rst=0 immediately forces state=IDLE, streak=0, and all outputs to 0, including data buses.
- Reset mid-transaction abandons it; no response is issued.

Outputs are all registered. States: IDLE, I_BUSY, D_BUSY, RESP.

IDLE:
- Samples requests each cycle.
- If a D request is present (d_read|d_write) and (no i_read or streak<MAX_D_STREAK): grant D.
  - Latch d_addr with bits[1:0] cleared, d_wdata, and lanes (d_byte_enable on write, 4'b1111 on read).
  - Next cycle: pmem_write=1 if d_write, else pmem_read=1.
  - streak <= streak+1 if i_read is also high, else 0.
- Else if i_read: grant I; latch i_addr; pmem_read=1 next cycle; streak <= 0.
- d_read and d_write both high: treated as a write.

I_BUSY / D_BUSY:
- Strobes, address, data and lanes held stable until pmem_resp.
- On pmem_resp:
  - Deassert strobes next cycle.
  - Capture pmem_rdata into the granted port's rdata.
  - Move to RESP.
  - Pulse the granted port's resp next cycle, but only if that port's request is still high in the pmem_resp cycle (see Withdrawal).

RESP:
- Lasts exactly one cycle; the resp pulse is visible here.
- Requests are ignored in this cycle, so the still-high request that was just answered is not regranted.
- Returns to IDLE.

Withdrawal:
- A request dropped before completion (pipeline flush) still completes on pmem; strobes are never retracted.
- No resp is pulsed and rdata stays 0.

Data and timing:
- rdata outputs are 0 except during their resp cycle.
- d_rdata on a write completion is don't-care; drive 0.
- Latency: request seen at cycle T -> strobe at T+1 -> pmem_resp at the earliest in T+1 -> resp at T+2.
- Back-to-back grants: the next grant is decided in the cycle after RESP (IDLE), giving 1 dead cycle.
- Only one transaction is ever outstanding on pmem.
- Streak saturates at MAX_D_STREAK; it clears when I is granted or when no I is pending at a D grant.

Test Plan:
- Reset: rst=0 during D_BUSY with pmem_read=1 -> all outputs 0 immediately; after release, with no requests, outputs stay 0 and no d_resp.
- Single fetch: i_read=1, i_addr=0x6000_0006; pmem_resp at T+3 with 0xDEADBEEF -> pmem_address=0x6000_0004 from T+1 to T+3, i_rdata=0xDEADBEEF and i_resp=1 at T+4 only, pmem_read=0 at T+4.
- Store: d_write=1, d_addr=0x100, d_wdata=0x1234_5678, d_byte_enable=4'b0011 -> pmem_write=1 with those values; single d_resp pulse; d_rdata=0.
- Contention with MAX_D_STREAK=2: i_read held, D requests re-presented continuously -> grant order D, D, I, D, D, I; i_resp arrives after exactly 2 D completions.
- Withdrawal: i_read dropped 1 cycle after grant -> pmem_read still held until pmem_resp; no i_resp; next request is granted normally.
- Simultaneous d_read and d_write -> write issued (pmem_write=1, pmem_read=0).
